// File: rtl/rf_pkg.sv
// Shared types and sizing for the random-forest vote accumulator.
package rf_pkg;

    localparam int RES_WIDTH   = 16;
    localparam int CLASS_WIDTH = 3;
    localparam int NUM_CLASS   = 8;
    localparam int FIFO_DEPTH  = 8;
    localparam int CNT_WIDTH   = 8;
    localparam int ADDR_WIDTH  = 10;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        RESOLVE,
        WRITE
    } vote_state_t;

endpackage

// File: rtl/rf_vote_accum_if.sv
// Result stream from the tree processor and the BRAM write port of the vote accumulator.
interface rf_vote_accum_if;
    import rf_pkg::*;

    logic                  res_fifo_we;
    logic [RES_WIDTH-1:0]  res_fifo_din;
    logic                  res_fifo_is_full;
    logic                  vote_we;
    logic [ADDR_WIDTH-1:0] vote_addr;
    logic [31:0]           vote_dout;

    modport master (
        output res_fifo_we,
        output res_fifo_din,
        input  res_fifo_is_full,
        input  vote_we,
        input  vote_addr,
        input  vote_dout
    );

    modport slave (
        input  res_fifo_we,
        input  res_fifo_din,
        output res_fifo_is_full,
        output vote_we,
        output vote_addr,
        output vote_dout
    );

endinterface

// File: rtl/rf_res_fifo.sv
// Synchronous result FIFO with registered full/empty, flush, and an overflow flag for dropped pushes.
module rf_res_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] C_FULL = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             r_full;
    logic             r_empty;
    logic             w_push;
    logic             w_pop;
    logic [PW:0]      w_count_nxt;

    assign w_push     = i_push && !r_full;
    assign w_pop      = i_pop && !r_empty;
    // A push against a full FIFO is lost even if a pop frees a slot this cycle.
    assign o_overflow = i_push && r_full;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == C_FULL);
            r_empty <= (w_count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/rf_vote_accum.sv
// Counts per-class tree votes per sample, resolves the majority class and writes one BRAM word per sample.
// Define RF_VOTE_CONF_OUT_EN to place the winning vote count in o_vote_dout[31:16].
module rf_vote_accum
    import rf_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    rf_vote_accum_if.slave       bus,
    input  logic                 i_vote_start,
    input  logic                 i_vote_end,
    input  logic [CNT_WIDTH-1:0] i_tree_cnt,
    output logic                 o_vote_busy,
    output logic                 o_err
);

    localparam logic [CLASS_WIDTH-1:0] LAST_IDX    = CLASS_WIDTH'(NUM_CLASS - 1);
    localparam logic [RES_WIDTH-1:0]   CLASS_LIMIT = RES_WIDTH'(NUM_CLASS);

    vote_state_t             r_state;
    logic [CNT_WIDTH-1:0]    r_tree_cnt;
    logic [CNT_WIDTH-1:0]    r_tree_idx;
    logic [CNT_WIDTH-1:0]    r_votes [NUM_CLASS];
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_err;
    logic                    r_vote_we;
    logic [31:0]             r_vote_dout;
    logic [CLASS_WIDTH-1:0]  r_res_idx;
    logic [CLASS_WIDTH-1:0]  r_best_idx;
`ifdef RF_VOTE_CONF_OUT_EN
    logic [CNT_WIDTH-1:0]    r_best_cnt;
    logic [CNT_WIDTH-1:0]    w_win_cnt;
`endif

    logic [RES_WIDTH-1:0]    w_fifo_dout;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic                    w_overflow;
    logic                    w_pop;
    logic [CLASS_WIDTH-1:0]  w_class;
    logic                    w_class_ok;
    logic [CNT_WIDTH-1:0]    w_cand_cnt;
    logic [CNT_WIDTH-1:0]    w_best_cnt;
    logic                    w_take;
    logic [CLASS_WIDTH-1:0]  w_win_idx;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    rf_res_fifo #(
        .WIDTH (RES_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (bus.res_fifo_we),
        .i_din      (bus.res_fifo_din),
        .i_pop      (w_pop),
        .i_flush    (i_vote_end),
        .o_dout     (w_fifo_dout),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty),
        .o_overflow (w_overflow)
    );

    assign w_pop      = (r_state == ACCUM) && !w_fifo_empty && !i_vote_end;
    // The whole word is range-checked, so stray upper bits are flagged rather than aliased onto a class.
    assign w_class    = w_fifo_dout[CLASS_WIDTH-1:0];
    assign w_class_ok = (w_fifo_dout < CLASS_LIMIT);

    assign w_cand_cnt = r_votes[r_res_idx];
`ifdef RF_VOTE_CONF_OUT_EN
    assign w_best_cnt = r_best_cnt;
    assign w_win_cnt  = w_take ? w_cand_cnt : w_best_cnt;
`else
    assign w_best_cnt = r_votes[r_best_idx];
`endif
    // Strictly greater keeps the lowest index on ties.
    assign w_take     = (w_cand_cnt > w_best_cnt);
    assign w_win_idx  = w_take ? r_res_idx : r_best_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_tree_cnt  <= '0;
            r_tree_idx  <= '0;
            r_addr      <= '0;
            r_err       <= 1'b0;
            r_vote_we   <= 1'b0;
            r_vote_dout <= '0;
            r_res_idx   <= '0;
            r_best_idx  <= '0;
`ifdef RF_VOTE_CONF_OUT_EN
            r_best_cnt  <= '0;
`endif
            for (int i = 0; i < NUM_CLASS; i++) begin
                r_votes[i] <= '0;
            end
        end else begin
            r_vote_we <= 1'b0;
            if (w_overflow) begin
                r_err <= 1'b1;
            end
            if (i_vote_end) begin
                r_state    <= IDLE;
                r_tree_idx <= '0;
                r_res_idx  <= '0;
                for (int i = 0; i < NUM_CLASS; i++) begin
                    r_votes[i] <= '0;
                end
            end else begin
                case (r_state)
                    IDLE: begin
                        if (i_vote_start) begin
                            if (i_tree_cnt == '0) begin
                                r_err <= 1'b1;
                            end else begin
                                r_state    <= ACCUM;
                                r_tree_cnt <= i_tree_cnt;
                                r_tree_idx <= '0;
                                r_addr     <= '0;
                                r_err      <= w_overflow;
                                for (int i = 0; i < NUM_CLASS; i++) begin
                                    r_votes[i] <= '0;
                                end
                            end
                        end
                    end
                    ACCUM: begin
                        if (w_pop) begin
                            if (w_class_ok) begin
                                r_votes[w_class] <= sat_inc(r_votes[w_class]);
                            end else begin
                                r_err <= 1'b1;
                            end
                            r_tree_idx <= r_tree_idx + 1'b1;
                            if (r_tree_idx == r_tree_cnt - 1'b1) begin
                                r_state    <= RESOLVE;
                                r_res_idx  <= '0;
                                r_best_idx <= '0;
`ifdef RF_VOTE_CONF_OUT_EN
                                r_best_cnt <= '0;
`endif
                            end
                        end
                    end
                    RESOLVE: begin
                        r_best_idx <= w_win_idx;
`ifdef RF_VOTE_CONF_OUT_EN
                        r_best_cnt <= w_win_cnt;
`endif
                        r_res_idx  <= r_res_idx + 1'b1;
                        if (r_res_idx == LAST_IDX) begin
                            r_state   <= WRITE;
                            r_vote_we <= 1'b1;
`ifdef RF_VOTE_CONF_OUT_EN
                            r_vote_dout <= {{(16 - CNT_WIDTH){1'b0}}, w_win_cnt,
                                            {(16 - CLASS_WIDTH){1'b0}}, w_win_idx};
`else
                            r_vote_dout <= {16'b0, {(16 - CLASS_WIDTH){1'b0}}, w_win_idx};
`endif
                        end
                    end
                    WRITE: begin
                        r_state    <= ACCUM;
                        r_addr     <= r_addr + 1'b1;
                        r_tree_idx <= '0;
                        for (int i = 0; i < NUM_CLASS; i++) begin
                            r_votes[i] <= '0;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.res_fifo_is_full = w_fifo_full;
    assign bus.vote_we          = r_vote_we;
    assign bus.vote_addr        = r_addr;
    assign bus.vote_dout        = r_vote_dout;
    assign o_vote_busy          = (r_state != IDLE);
    assign o_err                = r_err;

endmodule

// File: tb/tb_rf_vote_accum.sv
// Directed bench for rf_vote_accum with a write scoreboard fed by a majority-vote model.
`timescale 1ns/1ps
module tb_rf_vote_accum;
    import rf_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 i_vote_start;
    logic                 i_vote_end;
    logic [CNT_WIDTH-1:0] i_tree_cnt;
    logic                 o_vote_busy;
    logic                 o_err;

    rf_vote_accum_if bus();

    rf_vote_accum dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .i_vote_start (i_vote_start),
        .i_vote_end   (i_vote_end),
        .i_tree_cnt   (i_tree_cnt),
        .o_vote_busy  (o_vote_busy),
        .o_err        (o_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_WIDTH-1:0] addr;
        logic [31:0]           dout;
    } wr_t;

    int  cyc = 0;
    int  n_tests = 0;
    int  n_fail = 0;
    int  last_wr_cyc = -1;
    int  s0;
    int  saved;
    int  smp[$];
    wr_t exp_q[$];
    wr_t e_wr;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected BRAM word for the sample currently held in smp.
    function automatic wr_t model(input int addr);
        int  votes[NUM_CLASS];
        int  best;
        int  bc;
        wr_t w;
        best = 0;
        bc   = 0;
        for (int c = 0; c < NUM_CLASS; c++) votes[c] = 0;
        foreach (smp[i]) if (smp[i] >= 0 && smp[i] < NUM_CLASS) votes[smp[i]]++;
        for (int c = 0; c < NUM_CLASS; c++) begin
            if (votes[c] > bc) begin
                bc   = votes[c];
                best = c;
            end
        end
        w.addr = addr[ADDR_WIDTH-1:0];
`ifdef RF_VOTE_CONF_OUT_EN
        w.dout = 32'((bc << 16) | best);
`else
        w.dout = 32'(best);
`endif
        return w;
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.vote_we) begin
            last_wr_cyc = cyc;
            n_tests++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_write: observed addr %0d dout 0x%0h expected no write",
                       bus.vote_addr, bus.vote_dout);
            end
            if (exp_q.size() > 0) begin
                e_wr = exp_q.pop_front();
                check("wr_addr", 32'(bus.vote_addr), 32'(e_wr.addr));
                check("wr_dout", bus.vote_dout, e_wr.dout);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_smp();
        foreach (smp[i]) begin
            bus.res_fifo_we  = 1'b1;
            bus.res_fifo_din = RES_WIDTH'(smp[i]);
            step();
        end
        bus.res_fifo_we = 1'b0;
    endtask

    task automatic pulse_start(input int cnt);
        i_tree_cnt   = CNT_WIDTH'(cnt);
        i_vote_start = 1'b1;
        s0           = cyc;
        step();
        i_vote_start = 1'b0;
    endtask

    task automatic pulse_end();
        i_vote_end = 1'b1;
        step();
        i_vote_end = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc);
        for (int k = 0; k < max_cyc && exp_q.size() != 0; k++) step();
        check("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_we"},   32'(bus.vote_we), 32'd0);
        check({tag, "_addr"}, 32'(bus.vote_addr), 32'd0);
        check({tag, "_dout"}, bus.vote_dout, 32'd0);
        check({tag, "_busy"}, 32'(o_vote_busy), 32'd0);
        check({tag, "_err"},  32'(o_err), 32'd0);
        check({tag, "_full"}, 32'(bus.res_fifo_is_full), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n            = 1'b0;
        i_vote_start     = 1'b0;
        i_vote_end       = 1'b0;
        i_tree_cnt       = '0;
        bus.res_fifo_we  = 1'b0;
        bus.res_fifo_din = '0;
        #12;
        check_idle_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // Basic majority with latency check.
        smp = '{2, 2, 3, 2, 1};
        exp_q.push_back(model(0));
        push_smp();
        pulse_start(5);
        check("t1_busy", 32'(o_vote_busy), 32'd1);
        wait_drain(40);
        check("t1_latency", 32'(last_wr_cyc), 32'(s0 + 14));
        check("t1_addr_inc", 32'(bus.vote_addr), 32'd1);
        check("t1_we_low", 32'(bus.vote_we), 32'd0);

        // Ties resolve to the lowest class.
        pulse_end();
        check("t2_busy_end", 32'(o_vote_busy), 32'd0);
        smp = '{5, 1, 5, 1};
        exp_q.push_back(model(0));
        push_smp();
        smp = '{7, 7, 0, 0};
        exp_q.push_back(model(1));
        push_smp();
        check("t2_full", 32'(bus.res_fifo_is_full), 32'd1);
        pulse_start(4);
        wait_drain(80);
        check("t2_err", 32'(o_err), 32'd0);

        // Backlog overflow while idle.
        pulse_end();
        smp = '{3, 3, 6, 3, 6, 6, 6, 1};
        push_smp();
        check("t3_full", 32'(bus.res_fifo_is_full), 32'd1);
        check("t3_err_before", 32'(o_err), 32'd0);
        for (int i = 0; i < 24; i++) begin
            bus.res_fifo_we  = 1'b1;
            bus.res_fifo_din = RES_WIDTH'(2);
            step();
        end
        bus.res_fifo_we = 1'b0;
        check("t3_err_drop", 32'(o_err), 32'd1);
        check("t3_full_hold", 32'(bus.res_fifo_is_full), 32'd1);
        exp_q.push_back(model(0));
        pulse_start(8);
        check("t3_err_clr", 32'(o_err), 32'd0);
        wait_drain(60);
        smp = '{4, 4, 4, 0, 0, 1, 2, 3};
        exp_q.push_back(model(1));
        push_smp();
        wait_drain(60);
        check("t3_full_after", 32'(bus.res_fifo_is_full), 32'd0);

        // Out-of-range class id counts as a tree without a vote.
        pulse_end();
        pulse_start(3);
        smp = '{9, 4, 4};
        exp_q.push_back(model(0));
        push_smp();
        wait_drain(40);
        check("t4_err", 32'(o_err), 32'd1);

        // Abort during RESOLVE.
        pulse_end();
        pulse_start(2);
        smp = '{1, 1};
        exp_q.push_back(model(0));
        push_smp();
        wait_drain(40);
        smp = '{3, 3};
        push_smp();
        repeat (4) step();
        saved = last_wr_cyc;
        pulse_end();
        check("t5_busy", 32'(o_vote_busy), 32'd0);
        check("t5_addr_hold", 32'(bus.vote_addr), 32'd1);
        check("t5_full", 32'(bus.res_fifo_is_full), 32'd0);
        check("t5_err", 32'(o_err), 32'd0);
        repeat (20) step();
        check("t5_no_write", 32'(last_wr_cyc), 32'(saved));

        // Reset in the middle of ACCUM.
        pulse_start(1);
        smp = '{9};
        exp_q.push_back(model(0));
        push_smp();
        wait_drain(40);
        check("t6_err_set", 32'(o_err), 32'd1);
        check("t6_addr_pre", 32'(bus.vote_addr), 32'd1);
        check("t6_busy_pre", 32'(o_vote_busy), 32'd1);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("t6_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        pulse_start(2);
        smp = '{6, 6};
        exp_q.push_back(model(0));
        push_smp();
        wait_drain(40);
        check("t6_addr_post", 32'(bus.vote_addr), 32'd1);

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_vote_accum.md
Name: rf_vote_accum

Overview:
- Downstream neighbour of the decision-tree processor (dtp); consumes its per-tree result stream (res_fifo_we / res_fifo_dout, with res_fifo_is_full back-pressure).
- Buffers tree results in a small FIFO and counts per-class votes over i_tree_cnt trees per sample.
- Resolves the majority class and writes one word per sample into a PS-readable BRAM port at incrementing addresses.

Parameters:
- RES_WIDTH, 16, width of one dtp result word; class id is in bits [CLASS_WIDTH-1:0].
- CLASS_WIDTH, 3, class id width.
- NUM_CLASS, 8, classes counted (≤ 2**CLASS_WIDTH).
- FIFO_DEPTH, 8, input FIFO entries (power of 2).
- CNT_WIDTH, 8, vote counter and tree count width.
- ADDR_WIDTH, 10, BRAM word address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_res_fifo_we  in  1  push a result from dtp
- i_res_fifo_din  in  RES_WIDTH  result word
- o_res_fifo_is_full  out  1  FIFO full, routed to dtp i_res_fifo_is_full
- i_vote_start  in  1  one-cycle pulse: begin a run
- i_vote_end  in  1  one-cycle pulse: abort/finish run
- i_tree_cnt  in  CNT_WIDTH  trees per sample, latched on i_vote_start
- o_vote_we  out  1  BRAM write strobe
- o_vote_addr  out  ADDR_WIDTH  BRAM word address
- o_vote_dout  out  32  {16'b0 or winning count, 13'b0, class}
- o_vote_busy  out  1  state != IDLE
- o_err  out  1  sticky: overflow or class id ≥ NUM_CLASS

Behaviour:
- Reset: all outputs 0, FIFO empty, counters 0, state IDLE, latched tree count 0.
- FIFO:
  - Push when i_res_fifo_we && !full.
  - A push while full is dropped and sets o_err, even if a pop occurs in the same cycle.
  - o_res_fifo_is_full is registered (count == FIFO_DEPTH).
  - Pointers wrap modulo FIFO_DEPTH.
  - Pushes are accepted in every state, including IDLE.
- FSM states: IDLE, ACCUM, RESOLVE, WRITE.
  - IDLE → ACCUM on i_vote_start. Latch i_tree_cnt; set addr = 0; clear counters and o_err.
  - i_vote_start with i_tree_cnt = 0: stay IDLE and set o_err.
  - ACCUM: pop one entry per cycle while not empty.
    - Increment vote[class] (saturating at all-ones).
    - A class id ≥ NUM_CLASS counts as a tree but casts no vote, and sets o_err.
    - Increment tree_idx.
    - On the pop where tree_idx == tree_cnt-1, go to RESOLVE.
  - RESOLVE: sequential argmax, one class per cycle, exactly NUM_CLASS cycles. Strictly-greater compare, so a tie resolves to the lowest class index. All-zero votes give class 0.
  - WRITE: one cycle.
    - o_vote_we = 1; o_vote_dout = {conf, class} per the optional feature; o_vote_addr = current addr.
    - Next cycle: addr increments, wrapping at 2**ADDR_WIDTH; vote counters and tree_idx are cleared; state returns to ACCUM.
- Latency: the final pop occurs in cycle T; o_vote_we is asserted in cycle T+1+NUM_CLASS.
- The FIFO is not popped in RESOLVE or WRITE; dtp is throttled through full.
- i_vote_end, in any state:
  - Next state IDLE. A pending WRITE is not issued.
  - FIFO is flushed; counters are cleared. o_err and addr are held.
  - If i_vote_end and i_vote_start arrive in the same cycle, i_vote_end wins.
- i_vote_start while busy: ignored.
- Reset mid-run: immediate return to reset state, no write issued.

Optional Feature:
- Macro: RF_VOTE_CONF_OUT_EN.
- Defined: o_vote_dout[31:16] = winning vote count, zero-extended.
- Undefined: o_vote_dout[31:16] = 0, and the argmax keeps only the winning index (the count register for it is removed).

Decomposition:
- Shared package rf_pkg holds RES_WIDTH, CLASS_WIDTH, NUM_CLASS, CNT_WIDTH and the vote_state_t enum {IDLE, ACCUM, RESOLVE, WRITE}.
- One natural sub-module: rf_res_fifo, a synchronous FIFO with async reset, push/pop/full/empty and a flush input.

Test Plan:
- i_tree_cnt=5, push classes 2,2,3,2,1, then start → one write: addr 0, class 2, conf 3 (with macro), at cycle last_pop+1+8.
- Tie test, i_tree_cnt=4, classes 5,1,5,1 → class 1; second sample 7,7,0,0 → class 0 at addr 1.
- Hold pop off via a 4-sample backlog (32 pushes) → full asserts at 8 entries; 9th push dropped, o_err=1; later samples still vote on the retained data.
- Class id 9 with NUM_CLASS=8 in a 3-tree sample (9,4,4) → class 4, conf 2, o_err=1.
- i_vote_end asserted during RESOLVE → no o_vote_we; busy=0 the next cycle; FIFO empty; addr held.
- Reset asserted mid-ACCUM → all outputs 0 asynchronously; a fresh start begins writing at addr 0.
